even_count_monitor: RTL and testbench
=====================================

Name: even_count_monitor

Overview:
- Downstream checker for the 4-bit even up/down counter (outputs A,B,C,D with A as MSB, direction input Y, Y=1 counts up).
- Samples the counter outputs and Y on every rising clock edge and checks three things: the value is even, each step is exactly ±2 mod 16 in the direction sampled on the previous edge, and wrap-around events.
- Reports per-cycle error and wrap pulses, a sticky error flag and a saturating error count for the bench and for a status display.

Parameters:
- ERR_W, 8: width of the saturating error counter.

Ports:
- clock  input  1  rising-edge clock, the same clock that drives the counter
- reset  input  1  asynchronous, active-low reset
- A  input  1  counter bit 3 (MSB)
- B  input  1  counter bit 2
- C  input  1  counter bit 1
- D  input  1  counter bit 0 (LSB, must always be 0)
- Y  input  1  counter direction (1 = up, 0 = down)
- armed  output  1  high once a reference sample is held
- par_err  output  1  one-cycle pulse: sampled value is odd
- seq_err  output  1  one-cycle pulse: illegal step
- wrap_up  output  1  one-cycle pulse: 14 -> 0 step while counting up
- wrap_down  output  1  one-cycle pulse: 0 -> 14 step while counting down
- err_flag  output  1  sticky OR of par_err and seq_err
- err_count  output  ERR_W  saturating count of error cycles

Behaviour:
- Sampling:
  - q = {A,B,C,D} and Y are registered on every rising clock edge; there are no other inputs.
  - Internal registers: prev_q[3:0], prev_y, and a state register.
- Reset (reset=0, asynchronous):
  - state=EMPTY; prev_q=0; prev_y=0.
  - All outputs are 0.
  - Reset may be asserted mid-run. Nothing survives reset; the next edge after release is treated as the first sample.
- State machine: EMPTY, RUN (plus HALT, see Optional Feature).
- EMPTY, at an edge:
  - Store prev_q=q and prev_y=Y, then go to RUN and set armed=1.
  - Only the parity check applies: par_err=1 if D=1. No sequence check, no wrap pulses.
- RUN, at an edge:
  - exp = prev_q+2 mod 16 if prev_y=1, else prev_q-2 mod 16. Arithmetic is 4-bit unsigned with natural wrap.
  - par_err = D.
  - seq_err = (q != exp).
  - wrap_up = prev_y & prev_q==14 & q==0.
  - wrap_down = ~prev_y & prev_q==0 & q==14.
  - Always update prev_q=q and prev_y=Y. A single glitch therefore produces at most two seq_err pulses (leaving the bad value and returning from it), and the monitor then resynchronises.
- Direction change: the Y sampled at edge k governs the step checked at edge k+1. Example: q=6 with Y going 1->0 at that edge gives expected next value 4.
- Error accounting:
  - err_cycle = par_err | seq_err.
  - err_flag is set on err_cycle and is cleared only by reset.
  - err_count increments by 1 per err_cycle, even when both errors occur in the same cycle. It saturates at 2^ERR_W-1 and does not wrap.
- Output timing:
  - All outputs are registered and change one clock after the offending sample is presented, i.e. they are valid in the cycle after the checking edge.
  - Pulses last exactly one cycle unless the condition repeats.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: MON_HALT_ON_ERR_EN.
- Defined:
  - The first err_cycle moves the FSM to HALT. The pulses for that cycle still fire and err_count records 1.
  - In HALT: every pulse output is held 0, prev_q/prev_y/err_count are frozen, and armed stays 1.
  - HALT is left only by reset.
- Undefined: there is no HALT state and the monitor keeps checking and counting as described above.

Test Plan:
- Reset then up run: Y=1 from reset, counter runs 0,2,...,14,0,2. Required: armed=1 after the first edge, wrap_up pulses once when 14->0, zero errors, err_count=0.
- Down run with direction change: Y=1 up to 8, then Y=0. Counter goes 8,6,4,2,0,14. Required: no seq_err at the turnaround, and wrap_down pulses once when 0->14.
- Skip injection: force q sequence 4,6,10,12 with Y=1. Required: seq_err pulses at 10 only (12 is legal from 10), err_flag=1, err_count=1.
- Parity error: force q=5 between 4 and 6, Y=1. Required: par_err and seq_err both pulse on 5 and seq_err pulses again on 6. err_count=2.
- Saturation: ERR_W=2 with 5 consecutive error cycles. Required: err_count ends at 3 and err_flag stays 1.
- Reset mid-run: assert reset=0 asynchronously with err_flag=1. Required: all outputs are 0 immediately. After release, the first sample gives no seq_err regardless of its value.
- With MON_HALT_ON_ERR_EN: inject 2 errors. Required: err_count=1, pulses stay 0 after the first error, and the monitor recovers only via reset.

Source files
------------

// File: rtl/even_count_monitor.sv
// Checker for a 4-bit even up/down counter: parity, +/-2 step and wrap events.
// Latency: all outputs registered, valid the cycle after the checking edge.
// Backpressure: none; samples every rising edge. Optional halt-on-first-error via MON_HALT_ON_ERR_EN.
module even_count_monitor #(
   parameter int ERR_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             A,
   input  logic             B,
   input  logic             C,
   input  logic             D,
   input  logic             Y,
   output logic             armed,
   output logic             par_err,
   output logic             seq_err,
   output logic             wrap_up,
   output logic             wrap_down,
   output logic             err_flag,
   output logic [ERR_W-1:0] err_count
);

`ifdef MON_HALT_ON_ERR_EN
   typedef enum logic [1:0] {EMPTY, RUN, HALT} state_t;
`else
   typedef enum logic [1:0] {EMPTY, RUN} state_t;
`endif

   localparam logic [ERR_W-1:0] CNT_MAX = {ERR_W{1'b1}};
   localparam logic [ERR_W-1:0] CNT_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [3:0]       prev_val_q, prev_val_d;
   logic             prev_dir_q, prev_dir_d;
   logic             armed_q, armed_d;
   logic             par_err_q, par_err_d;
   logic             seq_err_q, seq_err_d;
   logic             wrap_up_q, wrap_up_d;
   logic             wrap_down_q, wrap_down_d;
   logic             err_flag_q, err_flag_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;

   logic [3:0]       cur_val;
   logic [3:0]       exp_val;
   logic             err_cycle;

   // Next-state, check evaluation and error accounting for the current sample.
   always_comb begin
      cur_val     = {A, B, C, D};
      exp_val     = prev_dir_q ? (prev_val_q + 4'd2) : (prev_val_q - 4'd2);
      state_d     = state_q;
      prev_val_d  = prev_val_q;
      prev_dir_d  = prev_dir_q;
      armed_d     = armed_q;
      par_err_d   = 1'b0;
      seq_err_d   = 1'b0;
      wrap_up_d   = 1'b0;
      wrap_down_d = 1'b0;
      err_flag_d  = err_flag_q;
      err_count_d = err_count_q;

      case (state_q)
         EMPTY: begin
            // First sample only establishes the reference; parity still applies.
            prev_val_d = cur_val;
            prev_dir_d = Y;
            armed_d    = 1'b1;
            state_d    = RUN;
            par_err_d  = D;
         end
         RUN: begin
            par_err_d   = D;
            seq_err_d   = (cur_val != exp_val);
            wrap_up_d   = prev_dir_q & (prev_val_q == 4'd14) & (cur_val == 4'd0);
            wrap_down_d = ~prev_dir_q & (prev_val_q == 4'd0) & (cur_val == 4'd14);
            // Always follow the observed value so a glitch costs at most two seq_err pulses.
            prev_val_d  = cur_val;
            prev_dir_d  = Y;
         end
         default: begin
            // HALT: everything frozen until reset.
         end
      endcase

      err_cycle = par_err_d | seq_err_d;
      if (err_cycle) begin
         err_flag_d = 1'b1;
         if (err_count_q != CNT_MAX) begin
            err_count_d = err_count_q + CNT_ONE;
         end
`ifdef MON_HALT_ON_ERR_EN
         state_d = HALT;
`endif
      end
   end

   // State, reference sample and registered outputs; async active-low reset clears all.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q     <= EMPTY;
         prev_val_q  <= 4'd0;
         prev_dir_q  <= 1'b0;
         armed_q     <= 1'b0;
         par_err_q   <= 1'b0;
         seq_err_q   <= 1'b0;
         wrap_up_q   <= 1'b0;
         wrap_down_q <= 1'b0;
         err_flag_q  <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         prev_val_q  <= prev_val_d;
         prev_dir_q  <= prev_dir_d;
         armed_q     <= armed_d;
         par_err_q   <= par_err_d;
         seq_err_q   <= seq_err_d;
         wrap_up_q   <= wrap_up_d;
         wrap_down_q <= wrap_down_d;
         err_flag_q  <= err_flag_d;
         err_count_q <= err_count_d;
      end
   end

   assign armed     = armed_q;
   assign par_err   = par_err_q;
   assign seq_err   = seq_err_q;
   assign wrap_up   = wrap_up_q;
   assign wrap_down = wrap_down_q;
   assign err_flag  = err_flag_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_even_count_monitor.sv
// Scoreboard bench for even_count_monitor: model pushes expectations, monitor pops and compares.
// Latency: expectation for a sample is compared one edge after it is presented.
// Backpressure: none; one expectation per sampling edge.
module tb_even_count_monitor;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic A = 1'b0, B = 1'b0, C = 1'b0, D = 1'b0, Y = 1'b0;

   logic       armed, par_err, seq_err, wrap_up, wrap_down, err_flag;
   logic [7:0] err_count;
   logic       armed2, par_err2, seq_err2, wrap_up2, wrap_down2, err_flag2;
   logic [1:0] err_count2;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   even_count_monitor #(.ERR_W(8)) dut (
      .clock(clock), .reset(reset), .A(A), .B(B), .C(C), .D(D), .Y(Y),
      .armed(armed), .par_err(par_err), .seq_err(seq_err),
      .wrap_up(wrap_up), .wrap_down(wrap_down),
      .err_flag(err_flag), .err_count(err_count)
   );

   even_count_monitor #(.ERR_W(2)) dut_sat (
      .clock(clock), .reset(reset), .A(A), .B(B), .C(C), .D(D), .Y(Y),
      .armed(armed2), .par_err(par_err2), .seq_err(seq_err2),
      .wrap_up(wrap_up2), .wrap_down(wrap_down2),
      .err_flag(err_flag2), .err_count(err_count2)
   );

   typedef struct packed {
      logic       armed;
      logic       par;
      logic       seq;
      logic       wu;
      logic       wd;
      logic       flag;
      logic [7:0] cnt;
      logic [1:0] cnt2;
   } exp_t;

   exp_t sb_q[$];

   // Reference model state: the last accepted sample and the accumulated error record.
   bit m_have_ref = 0;
   int m_ref_val  = 0;
   bit m_ref_dir  = 0;
   bit m_halted   = 0;
   bit m_flag     = 0;
   int m_cnt      = 0;
   int m_cnt2     = 0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
      end
   endtask

   // Present one sample at the falling edge and push what the monitor must report after the next rising edge.
   task automatic apply(input int v, input bit y, input bit rst);
      exp_t e;
      bit   p, s, err;
      int   want;
      @(negedge clock);
      reset = rst;
      {A, B, C, D} = 4'(v);
      Y = y;
      e = '0;
      if (!rst) begin
         m_have_ref = 0; m_halted = 0; m_flag = 0; m_cnt = 0; m_cnt2 = 0;
      end else if (m_halted) begin
         e.armed = 1;
         e.flag  = m_flag;
         e.cnt   = 8'(m_cnt);
         e.cnt2  = 2'(m_cnt2);
      end else begin
         want = m_ref_dir ? (m_ref_val + 2) % 16 : (m_ref_val + 14) % 16;
         p = (v % 2) == 1;
         s = m_have_ref && (v != want);
         e.wu = m_have_ref && m_ref_dir && m_ref_val == 14 && v == 0;
         e.wd = m_have_ref && !m_ref_dir && m_ref_val == 0 && v == 14;
         err = p | s;
         if (err) begin
            m_flag = 1;
            m_cnt  = (m_cnt  < 255) ? m_cnt  + 1 : 255;
            m_cnt2 = (m_cnt2 < 3)   ? m_cnt2 + 1 : 3;
`ifdef MON_HALT_ON_ERR_EN
            m_halted = 1;
`endif
         end
         e.armed = 1;
         e.par   = p;
         e.seq   = s;
         e.flag  = m_flag;
         e.cnt   = 8'(m_cnt);
         e.cnt2  = 2'(m_cnt2);
         m_have_ref = 1;
         m_ref_val  = v;
         m_ref_dir  = y;
      end
      sb_q.push_back(e);
      if (!rst) begin
         // Reset is asynchronous: outputs must already be clear before any edge.
         #1;
         chk("rst_async_outputs",
             int'({armed, par_err, seq_err, wrap_up, wrap_down, err_flag}), 0);
         chk("rst_async_count", int'(err_count), 0);
      end
   endtask

   // Monitor: compare DUT outputs against the oldest expectation shortly after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("armed",     int'(armed),      int'(e.armed));
            chk("par_err",   int'(par_err),    int'(e.par));
            chk("seq_err",   int'(seq_err),    int'(e.seq));
            chk("wrap_up",   int'(wrap_up),    int'(e.wu));
            chk("wrap_down", int'(wrap_down),  int'(e.wd));
            chk("err_flag",  int'(err_flag),   int'(e.flag));
            chk("err_count", int'(err_count),  int'(e.cnt));
            chk("sat_count", int'(err_count2), int'(e.cnt2));
            chk("sat_flag",  int'(err_flag2),  int'(e.flag));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog t=%0t actual=timeout required=finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int up_seq[10]   = '{0, 2, 4, 6, 8, 10, 12, 14, 0, 2};
      int dn_seq[8]    = '{4, 6, 8, 6, 4, 2, 0, 14};
      int skip_seq[4]  = '{4, 6, 10, 12};
      int par_seq[3]   = '{4, 5, 6};
      int cv;
      bit dir;
      int v;

      // Reset, then a clean up run through the 14 -> 0 wrap.
      apply(0, 1, 0);
      apply(0, 1, 0);
      foreach (up_seq[i]) apply(up_seq[i], 1'b1, 1'b1);

      // Up to 8, turn around there, and wrap downward through 0 -> 14.
      apply(0, 1, 0);
      foreach (dn_seq[i]) apply(dn_seq[i], (i < 2) ? 1'b1 : 1'b0, 1'b1);

      // A skipped value: only the jump into 10 is illegal.
      apply(0, 1, 0);
      foreach (skip_seq[i]) apply(skip_seq[i], 1'b1, 1'b1);

      // An odd glitch costs a parity error plus two sequence errors.
      apply(0, 1, 0);
      foreach (par_seq[i]) apply(par_seq[i], 1'b1, 1'b1);

      // Five error cycles in a row drive the 2-bit counter to saturation.
      apply(0, 1, 0);
      for (int i = 0; i < 5; i++) apply(1, 1'b1, 1'b1);

      // Mid-run reset with the flag set; the first sample afterwards is reference only.
      apply(6, 1, 0);
      apply(10, 0, 1);
      apply(8, 0, 1);

      // Randomized counter traffic with direction changes, glitches and occasional resets.
      cv  = 2 * $urandom_range(0, 7);
      dir = 1'($urandom_range(0, 1));
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 79) == 0) begin
            apply(cv, dir, 1'b0);
         end else begin
            v = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : cv;
            apply(v, dir, 1'b1);
            cv = dir ? (cv + 2) % 16 : (cv + 14) % 16;
            if ($urandom_range(0, 6) == 0) dir = ~dir;
         end
      end

      @(negedge clock);
      @(negedge clock);
      chk("sb_drain", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
